// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM encodings, port count
// and the ALUOp codes used by the requesters.
package alu_arbiter_pkg;

  localparam int ARB_NREQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [4:0] ALUOp_nop   = 5'd0;
  localparam logic [4:0] ALUOp_lui   = 5'd1;
  localparam logic [4:0] ALUOp_auipc = 5'd2;
  localparam logic [4:0] ALUOp_add   = 5'd3;
  localparam logic [4:0] ALUOp_sub   = 5'd4;
  localparam logic [4:0] ALUOp_bne   = 5'd5;
  localparam logic [4:0] ALUOp_blt   = 5'd6;
  localparam logic [4:0] ALUOp_bge   = 5'd7;
  localparam logic [4:0] ALUOp_bltu  = 5'd8;
  localparam logic [4:0] ALUOp_bgeu  = 5'd9;
  localparam logic [4:0] ALUOp_slt   = 5'd10;
  localparam logic [4:0] ALUOp_sltu  = 5'd11;
  localparam logic [4:0] ALUOp_xor   = 5'd12;
  localparam logic [4:0] ALUOp_or    = 5'd13;
  localparam logic [4:0] ALUOp_and   = 5'd14;
  localparam logic [4:0] ALUOp_sll   = 5'd15;
  localparam logic [4:0] ALUOp_srl   = 5'd16;
  localparam logic [4:0] ALUOp_sra   = 5'd17;

  function automatic logic [ARB_NREQ-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational two-way grant picker. Round-robin by default; build with
// ALU_ARB_FIXED_PRIO_EN to make port 0 win every contention.
module alu_rr_pick
  import alu_arbiter_pkg::*;
(
  input  logic [ARB_NREQ-1:0] valid,
  input  logic                last_grant,
  output logic [ARB_NREQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant[0] = valid[0];
  assign grant[1] = valid[1] & ~valid[0];
`else
  // On contention the port that did not win last time goes first.
  assign grant[0] = valid[0] & (~valid[1] |  last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, latch operands,
// drive the ALU for one cycle, hold the result until the owner takes it.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [WIDTH-1:0] rq0_a,
  input  logic [WIDTH-1:0] rq0_b,
  input  logic [OPW-1:0]   rq0_op,
  input  logic [WIDTH-1:0] rq0_pc,
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [WIDTH-1:0] rq1_a,
  input  logic [WIDTH-1:0] rq1_b,
  input  logic [OPW-1:0]   rq1_op,
  input  logic [WIDTH-1:0] rq1_pc,
  output logic             rs0_valid,
  input  logic             rs0_ready,
  output logic             rs1_valid,
  input  logic             rs1_ready,
  output logic [WIDTH-1:0] rs_c,
  output logic             rs_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_pc,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  arb_state_e                         state;
  logic                               owner;
  logic [WIDTH-1:0]                   lat_a, lat_b, lat_pc;
  logic [OPW-1:0]                     lat_op;
  logic [ARB_NREQ-1:0]                rs_vld;

  logic [ARB_NREQ-1:0]                rq_valid, rq_rdy, rs_rdy, grant, hs;
  logic [ARB_NREQ-1:0][WIDTH-1:0]     rq_a, rq_b, rq_pc;
  logic [ARB_NREQ-1:0][OPW-1:0]       rq_op;
  logic                               sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
  assign last_grant = 1'b0;
`else
  logic last_grant;
`endif

  assign rq_valid = {rq1_valid, rq0_valid};
  assign rs_rdy   = {rs1_ready, rs0_ready};
  assign rq_a     = {rq1_a,  rq0_a};
  assign rq_b     = {rq1_b,  rq0_b};
  assign rq_pc    = {rq1_pc, rq0_pc};
  assign rq_op    = {rq1_op, rq0_op};

  alu_rr_pick u_pick (
    .valid      (rq_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by reset so nothing looks accepted while the block is held.
  assign rq_rdy    = (rstn && state == ARB_IDLE) ? grant : '0;
  assign rq0_ready = rq_rdy[0];
  assign rq1_ready = rq_rdy[1];
  assign hs        = rq_valid & rq_rdy;
  assign sel       = hs[1];

  assign rs0_valid = rs_vld[0];
  assign rs1_valid = rs_vld[1];

  assign alu_a  = lat_a;
  assign alu_b  = lat_b;
  assign alu_pc = lat_pc;
  assign alu_op = lat_op;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB_IDLE;
      owner   <= 1'b0;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_pc  <= '0;
      lat_op  <= '0;
      rs_c    <= '0;
      rs_zero <= 1'b0;
      rs_vld  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        ARB_IDLE: if (|hs) begin
          lat_a  <= rq_a[sel];
          lat_b  <= rq_b[sel];
          lat_pc <= rq_pc[sel];
          lat_op <= rq_op[sel];
          owner  <= sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant <= sel;
`endif
          state  <= ARB_EXEC;
        end
        ARB_EXEC: begin
          rs_c    <= alu_c;
          rs_zero <= alu_zero;
          rs_vld  <= port_onehot(owner);
          state   <= ARB_RESP;
        end
        ARB_RESP: if (|(rs_vld & rs_rdy)) begin
          rs_vld <= '0;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter: a transaction-level model
// predicts grants/results into a scoreboard that a negedge monitor checks.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [31:0] rq0_a, rq0_b, rq0_pc, rq1_a, rq1_b, rq1_pc;
  logic [4:0]  rq0_op, rq1_op;
  logic        rs0_valid, rs0_ready, rs1_valid, rs1_ready;
  logic [31:0] rs_c;
  logic        rs_zero;
  logic [31:0] alu_a, alu_b, alu_pc, alu_c;
  logic [4:0]  alu_op;
  logic        alu_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clk(clk), .rstn(rstn),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq0_op(rq0_op), .rq0_pc(rq0_pc),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rq1_op(rq1_op), .rq1_pc(rq1_pc),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready),
    .rs1_valid(rs1_valid), .rs1_ready(rs1_ready),
    .rs_c(rs_c), .rs_zero(rs_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, b, pc);
    case (op)
      ALUOp_lui:   return b;
      ALUOp_auipc: return pc + b;
      ALUOp_add:   return a + b;
      ALUOp_sub:   return a - b;
      ALUOp_xor:   return a ^ b;
      ALUOp_or:    return a | b;
      ALUOp_and:   return a & b;
      ALUOp_sll:   return a << b[4:0];
      ALUOp_srl:   return a >> b[4:0];
      ALUOp_sra:   return $unsigned($signed(a) >>> b[4:0]);
      ALUOp_slt:   return {31'b0, $signed(a) < $signed(b)};
      ALUOp_sltu:  return {31'b0, a < b};
      default:     return 32'h0;
    endcase
  endfunction

  // Stand-in for the external shared ALU.
  assign alu_c    = alu_ref(alu_op, alu_a, alu_b, alu_pc);
  assign alu_zero = (alu_c == 32'h0);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          owner;
    logic [31:0] a, b, pc, c;
    logic [4:0]  op;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  exp_t m_cur;
  int   m_phase = 0;   // 0 free, 1 ALU cycle, 2 result waiting
  int   m_last  = 1;
  int   glog[$];

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int   w;
    exp_t e;
    if (!rstn) begin
      m_phase = 0;
      m_last  = 1;
      sbq.delete();
    end else begin
      case (m_phase)
        0: begin
          w = pick(rq0_valid, rq1_valid);
          if (w >= 0) begin
            e.owner = w;
            e.a  = (w == 0) ? rq0_a  : rq1_a;
            e.b  = (w == 0) ? rq0_b  : rq1_b;
            e.pc = (w == 0) ? rq0_pc : rq1_pc;
            e.op = (w == 0) ? rq0_op : rq1_op;
            e.c  = alu_ref(e.op, e.a, e.b, e.pc);
            e.z  = (e.c == 32'h0);
            sbq.push_back(e);
            m_cur   = e;
            m_last  = w;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: if ((m_cur.owner == 0) ? rs0_ready : rs1_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int w;
    w = pick(rq0_valid, rq1_valid);
    chk("rq0_ready", {31'b0, rq0_ready}, {31'b0, rstn && m_phase == 0 && w == 0});
    chk("rq1_ready", {31'b0, rq1_ready}, {31'b0, rstn && m_phase == 0 && w == 1});
    if (rq0_valid && rq0_ready) glog.push_back(0);
    else if (rq1_valid && rq1_ready) glog.push_back(1);
    chk("rs0_valid", {31'b0, rs0_valid}, {31'b0, rstn && m_phase == 2 && m_cur.owner == 0});
    chk("rs1_valid", {31'b0, rs1_valid}, {31'b0, rstn && m_phase == 2 && m_cur.owner == 1});
    if (!rstn) begin
      chk("rst_rs_c",  rs_c, 32'h0);
      chk("rst_zero",  {31'b0, rs_zero}, 32'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);
      chk("rst_alu_pc", alu_pc, 32'h0);
      chk("rst_alu_op", {27'b0, alu_op}, 32'h0);
    end else if (m_phase == 1) begin
      chk("exec_alu_a",  alu_a,  m_cur.a);
      chk("exec_alu_b",  alu_b,  m_cur.b);
      chk("exec_alu_pc", alu_pc, m_cur.pc);
      chk("exec_alu_op", {27'b0, alu_op}, {27'b0, m_cur.op});
    end
    if (rs0_valid || rs1_valid) begin
      chk("sb_nonempty", {31'b0, sbq.size() != 0}, 32'h1);
      if (sbq.size() != 0) begin
        chk("rs_c", rs_c, sbq[0].c);
        chk("rs_zero", {31'b0, rs_zero}, {31'b0, sbq[0].z});
        if ((rs0_valid && rs0_ready) || (rs1_valid && rs1_ready)) void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] ops [12] = '{ALUOp_lui, ALUOp_auipc, ALUOp_add, ALUOp_sub, ALUOp_xor, ALUOp_or,
                           ALUOp_and, ALUOp_sll, ALUOp_srl, ALUOp_sra, ALUOp_slt, ALUOp_sltu};

  initial begin
    int exp2 [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp2 = '{0, 0, 0, 0};
`else
    exp2 = '{0, 1, 0, 1};
`endif
    rstn = 1'b0;
    rq0_valid = 0; rq0_a = 0; rq0_b = 0; rq0_op = 0; rq0_pc = 0;
    rq1_valid = 0; rq1_a = 0; rq1_b = 0; rq1_op = 0; rq1_pc = 0;
    rs0_ready = 1; rs1_ready = 1;
    repeat (3) tick();
    rstn = 1'b1;

    // single add on port 0: result visible one edge after the ALU cycle
    rq0_valid = 1; rq0_op = ALUOp_add; rq0_a = 5; rq0_b = 7;
    tick();
    rq0_valid = 0;
    tick();
    chk("t1_rs0_valid", {31'b0, rs0_valid}, 32'h1);
    chk("t1_rs1_valid", {31'b0, rs1_valid}, 32'h0);
    chk("t1_rs_c", rs_c, 32'd12);
    chk("t1_rs_zero", {31'b0, rs_zero}, 32'h0);
    repeat (3) tick();

    // contention straight after reset
    rstn = 0; tick(); rstn = 1;
    glog.delete();
    rq0_valid = 1; rq0_op = ALUOp_or; rq0_a = 32'h10; rq0_b = 32'h1;
    rq1_valid = 1; rq1_op = ALUOp_and; rq1_a = 32'hff; rq1_b = 32'h0f;
    repeat (12) tick();
    rq0_valid = 0; rq1_valid = 0;
    repeat (3) tick();
    chk("t2_grant_count", {31'b0, glog.size() >= 4}, 32'h1);
    for (int i = 0; i < 4; i++)
      if (i < glog.size()) chk($sformatf("t2_grant%0d", i), glog[i], exp2[i]);

    // backpressure on port 1 with port 0 knocking
    rs1_ready = 0;
    rq1_valid = 1; rq1_op = ALUOp_sub; rq1_a = 3; rq1_b = 3;
    tick();
    rq1_valid = 0; rq0_valid = 1; rq0_op = ALUOp_add;
    tick();
    repeat (10) begin
      tick();
      chk("t3_rs_c", rs_c, 32'h0);
      chk("t3_rs_zero", {31'b0, rs_zero}, 32'h1);
      chk("t3_rq0_ready", {31'b0, rq0_ready}, 32'h0);
    end
    rs1_ready = 1; rq0_valid = 0;
    repeat (4) tick();

    // auipc on port 1
    rq1_valid = 1; rq1_op = ALUOp_auipc; rq1_pc = 32'h100; rq1_b = 32'h2000; rq1_a = $urandom;
    tick();
    rq1_valid = 0;
    chk("t4_alu_pc", alu_pc, 32'h100);
    tick();
    chk("t4_rs_c", rs_c, 32'h2100);
    chk("t4_rs1_valid", {31'b0, rs1_valid}, 32'h1);
    repeat (3) tick();

    // reset during the ALU cycle
    rq0_valid = 1; rq0_op = ALUOp_add; rq0_a = 1; rq0_b = 2;
    tick();
    rq1_valid = 1;
    rstn = 0;
    #2;
    chk("t5_rs0_valid", {31'b0, rs0_valid}, 32'h0);
    chk("t5_rq0_ready", {31'b0, rq0_ready}, 32'h0);
    chk("t5_rq1_ready", {31'b0, rq1_ready}, 32'h0);
    tick(); tick();
    glog.delete();
    rstn = 1;
    repeat (4) tick();
    rq0_valid = 0; rq1_valid = 0;
    chk("t5_first_grant", (glog.size() != 0) ? glog[0] : -1, 0);
    repeat (4) tick();

    // port 1 pulses valid only while port 0's result is waiting
    rs0_ready = 0;
    rq0_valid = 1; rq0_op = ALUOp_xor; rq0_a = 32'hf0; rq0_b = 32'h0f;
    tick();
    rq0_valid = 0;
    tick();
    glog.delete();
    rq1_valid = 1; tick(); tick(); rq1_valid = 0;
    rs0_ready = 1;
    repeat (4) tick();
    chk("t6_no_rq1", glog.size(), 0);

    // random traffic, operands churn every cycle
    repeat (500) begin
      rq0_valid = 1'($urandom_range(0, 1)); rq1_valid = 1'($urandom_range(0, 1));
      rq0_op = ops[$urandom_range(0, 11)]; rq1_op = ops[$urandom_range(0, 11)];
      rq0_a = $urandom; rq0_b = (($urandom_range(0, 3) == 0) ? rq0_a : $urandom); rq0_pc = $urandom;
      rq1_a = $urandom; rq1_b = $urandom; rq1_pc = $urandom;
      rs0_ready = ($urandom_range(0, 2) != 0); rs1_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rq0_valid = 0; rq1_valid = 0; rs0_ready = 1; rs1_ready = 1;
    repeat (6) tick();
    chk("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
